ram_1port_arbiter: RTL and testbench
====================================

# ram_1port_arbiter

Two-requester arbiter that shares one single-port RAM (one address, write-valid, read-enable, read data valid one clock after read-enable) between requesters A and B. Each requester issues one read or write per cycle through a request/acknowledge handshake. The block grants ownership with a bounded-burst policy, registers the selected command onto the RAM port, and routes each returning read word to the requester that issued it. It sits between two client engines and the RAM instance.

## Interface
Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, RAM words; address width AW = $clog2(DEPTH).
- MAX_BURST, 4, maximum consecutive accepts for one owner while the other requests (≥1).

Ports:
- i_Clk  in  1  clock; all logic rising-edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_A_Req / i_B_Req  in  1  command valid; held with fields until acked.
- i_A_Wr / i_B_Wr  in  1  1 = write, 0 = read.
- i_A_Addr / i_B_Addr  in  AW  word address.
- i_A_Wr_Data / i_B_Wr_Data  in  WIDTH  write data.
- o_A_Ack / o_B_Ack  out  1  command accepted this cycle (combinational).
- o_A_Rd_DV / o_B_Rd_DV  out  1  read data valid for that requester.
- o_A_Rd_Data / o_B_Rd_Data  out  WIDTH  read data (both driven from RAM data).
- o_Ram_Addr  out  AW  registered RAM address.
- o_Ram_Wr_DV  out  1  registered RAM write strobe.
- o_Ram_Wr_Data  out  WIDTH  registered RAM write data.
- o_Ram_Rd_En  out  1  registered RAM read enable.
- i_Ram_Rd_DV  in  1  RAM read valid.
- i_Ram_Rd_Data  in  WIDTH  RAM read data.

## Operation
- States: IDLE, OWN_A, OWN_B. Burst counter CNT, width $clog2(MAX_BURST+1). LAST register holds the most recent owner.
- IDLE: only one requester → grant it, CNT=1. Both requesting → tie-break (see Configuration). Neither → stay IDLE.
- OWN_X, X requesting, and (CNT<MAX_BURST or other idle) → accept X, CNT saturates at MAX_BURST.
- OWN_X, other requesting, and (X idle or CNT==MAX_BURST) → accept other in the same cycle with no bubble, go to OWN_other, CNT=1.
- OWN_X, neither requesting → IDLE, CNT=0, LAST=X.
- At most one ack per cycle. An ack is never asserted without its Req.
- Accepted command: o_Ram_Wr_DV=Wr, o_Ram_Rd_En=!Wr, addr and data registered at the same edge. With no accept, both strobes are 0 and addr/data hold.
- Read tag: a {valid, owner} register is captured with each read command, then delayed one further stage to align with i_Ram_Rd_DV.
- o_X_Rd_DV = i_Ram_Rd_DV & tag2.valid & (tag2.owner==X).
- Writes never create tags.

## Timing
- Cycle N: Req and Ack both high. Edge ending N: o_Ram_* updated. Cycle N+1: RAM samples. Cycle N+2: o_X_Rd_DV/data valid. Read latency is 2 cycles from ack.
- Sustained throughput: one access per cycle. Switching owners costs no cycle.
- Reset values: state IDLE, LAST=B, CNT=0, o_Ram_Wr_DV=0, o_Ram_Rd_En=0, o_Ram_Addr=0, o_Ram_Wr_Data=0, tag valids 0.
- While i_Rst is high, acks are forced to 0, so o_*_Rd_DV=0.
- Reset mid-operation: in-flight reads are dropped. Their returns are suppressed because the tags are cleared. No command issues in the cycle after reset.
- Back-to-back reads from different owners return in issue order, each tagged correctly.
- Address wrap is the requester's concern. The address is passed unmodified.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: an IDLE tie goes to the requester that is not LAST (A wins the first tie after reset).
- Undefined: an IDLE tie always goes to A. LAST is still maintained but unused.
- The burst limit applies in both builds.

## Test plan
- A-only writes of data 1,2,3,4 to addr 0..3 back-to-back → o_A_Ack high 4 consecutive cycles; o_Ram_Wr_DV high 4 cycles starting one cycle later; o_B_Ack never high.
- After the writes, A reads addr 2 → o_A_Rd_DV exactly 2 cycles after ack with data 3; o_B_Rd_DV stays 0.
- A and B request continuously from reset, MAX_BURST=4 → acks run 4×A, 4×B, 4×A… with no idle RAM cycle.
- Both request from IDLE after B was last owner → A first. Repeat after A was last owner → B first (macro on), A first (macro off).
- A reads addr 1 in cycle N, B reads addr 3 in cycle N+1 → o_A_Rd_DV with data 2 at N+2, o_B_Rd_DV with data 4 at N+3.
- i_Rst pulsed one cycle after an A read ack → no o_A_Rd_DV. o_Ram_Rd_En is 0 after reset, and the state returns to IDLE.

Source files
------------

// File: rtl/ram_1port_arbiter.sv
// Purpose: shares one single-port RAM between requesters A and B with a bounded-burst owner policy.
// Latency: command registered onto the RAM port at the accepting edge; read data returns 2 cycles after ack.
// Backpressure: a requester holds Req and its fields until its Ack; at most one Ack per cycle, none during reset.
// Build option: define RAM_ARB_ROUND_ROBIN_EN to break idle ties toward the requester that did not own last.
module ram_1port_arbiter #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int MAX_BURST = 4,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_A_Req,
  input  logic             i_A_Wr,
  input  logic [AW-1:0]    i_A_Addr,
  input  logic [WIDTH-1:0] i_A_Wr_Data,
  output logic             o_A_Ack,
  output logic             o_A_Rd_DV,
  output logic [WIDTH-1:0] o_A_Rd_Data,
  input  logic             i_B_Req,
  input  logic             i_B_Wr,
  input  logic [AW-1:0]    i_B_Addr,
  input  logic [WIDTH-1:0] i_B_Wr_Data,
  output logic             o_B_Ack,
  output logic             o_B_Rd_DV,
  output logic [WIDTH-1:0] o_B_Rd_Data,
  output logic [AW-1:0]    o_Ram_Addr,
  output logic             o_Ram_Wr_DV,
  output logic [WIDTH-1:0] o_Ram_Wr_Data,
  output logic             o_Ram_Rd_En,
  input  logic             i_Ram_Rd_DV,
  input  logic [WIDTH-1:0] i_Ram_Rd_Data
);

  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_OWN_A = 2'd1;
  localparam logic [1:0]    ST_OWN_B = 2'd2;
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BURST);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Read tag: which requester a read belongs to, carried alongside the RAM pipeline.
  typedef struct packed {
    logic vld;
    logic own_b;
  } tag_t;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_b;
  logic          tie_to_a;
  logic          grant_a;
  logic          grant_b;
  logic          accept;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data;
  tag_t          tag1;
  tag_t          tag2;

  // In the fixed-priority build the tie always goes to A; LAST is still tracked either way.
  assign tie_to_a = !RR_EN || last_b;

  // Grant selection: bounded burst for the current owner, zero-bubble handover to the other side.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!i_Rst) begin
      case (state)
        ST_IDLE: begin
          if (i_A_Req && i_B_Req) begin
            grant_a = tie_to_a;
            grant_b = !tie_to_a;
          end else begin
            grant_a = i_A_Req;
            grant_b = i_B_Req;
          end
        end
        ST_OWN_A: begin
          if (i_A_Req && ((cnt < MAX_CNT) || !i_B_Req)) grant_a = 1'b1;
          else                                          grant_b = i_B_Req;
        end
        ST_OWN_B: begin
          if (i_B_Req && ((cnt < MAX_CNT) || !i_A_Req)) grant_b = 1'b1;
          else                                          grant_a = i_A_Req;
        end
        default: begin
          grant_a = 1'b0;
          grant_b = 1'b0;
        end
      endcase
    end
  end

  assign o_A_Ack  = grant_a;
  assign o_B_Ack  = grant_b;
  assign accept   = grant_a | grant_b;
  assign sel_wr   = grant_b ? i_B_Wr      : i_A_Wr;
  assign sel_addr = grant_b ? i_B_Addr    : i_A_Addr;
  assign sel_data = grant_b ? i_B_Wr_Data : i_A_Wr_Data;

  // Ownership, burst count and last-owner tracking.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      last_b <= 1'b1;
    end else if (grant_a) begin
      state <= ST_OWN_A;
      if (state == ST_OWN_A) cnt <= (cnt == MAX_CNT) ? MAX_CNT : cnt + CW'(1);
      else                   cnt <= CW'(1);
    end else if (grant_b) begin
      state <= ST_OWN_B;
      if (state == ST_OWN_B) cnt <= (cnt == MAX_CNT) ? MAX_CNT : cnt + CW'(1);
      else                   cnt <= CW'(1);
    end else begin
      if (state != ST_IDLE) last_b <= (state == ST_OWN_B);
      state <= ST_IDLE;
      cnt   <= '0;
    end
  end

  // Register the accepted command onto the RAM port; address/data hold when nothing is accepted.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Ram_Wr_DV   <= 1'b0;
      o_Ram_Rd_En   <= 1'b0;
      o_Ram_Addr    <= '0;
      o_Ram_Wr_Data <= '0;
    end else begin
      o_Ram_Wr_DV <= accept && sel_wr;
      o_Ram_Rd_En <= accept && !sel_wr;
      if (accept) begin
        o_Ram_Addr    <= sel_addr;
        o_Ram_Wr_Data <= sel_data;
      end
    end
  end

  // Two-stage read tag pipeline, aligned with the RAM's one-cycle read return.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      tag1.vld   <= accept && !sel_wr;
      tag1.own_b <= grant_b;
      tag2       <= tag1;
    end
  end

  // Route the returning word to the requester that issued it; nothing is delivered during reset.
  assign o_A_Rd_DV   = !i_Rst && i_Ram_Rd_DV && tag2.vld && !tag2.own_b;
  assign o_B_Rd_DV   = !i_Rst && i_Ram_Rd_DV && tag2.vld &&  tag2.own_b;
  assign o_A_Rd_Data = i_Ram_Rd_Data;
  assign o_B_Rd_Data = i_Ram_Rd_Data;

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// Purpose: randomized and directed bench for ram_1port_arbiter against a rule-level reference model.
// Latency: checks RAM-port registers one cycle after ack and read returns two cycles after ack.
// Backpressure: requesters hold commands until acked; the bench RAM answers reads one cycle after Rd_En.
module tb_ram_1port_arbiter;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int AW        = 2;
  localparam int MAX_BURST = 4;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic r_Clk = 1'b0;
  always #5 r_Clk = ~r_Clk;

  logic             r_Rst  = 1'b1;
  logic             a_req  = 1'b0;
  logic             a_wr   = 1'b0;
  logic [AW-1:0]    a_addr = '0;
  logic [WIDTH-1:0] a_wdat = '0;
  logic             b_req  = 1'b0;
  logic             b_wr   = 1'b0;
  logic [AW-1:0]    b_addr = '0;
  logic [WIDTH-1:0] b_wdat = '0;
  logic             a_ack, b_ack, a_rd_dv, b_rd_dv;
  logic [WIDTH-1:0] a_rd_dat, b_rd_dat;
  logic [AW-1:0]    ram_addr;
  logic             ram_wr_dv, ram_rd_en;
  logic [WIDTH-1:0] ram_wr_dat;
  logic             ram_rd_dv = 1'b0;
  logic [WIDTH-1:0] ram_rd_dat = '0;
  logic [WIDTH-1:0] mem [DEPTH];

  ram_1port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .i_Clk(r_Clk), .i_Rst(r_Rst),
    .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr), .i_A_Wr_Data(a_wdat),
    .o_A_Ack(a_ack), .o_A_Rd_DV(a_rd_dv), .o_A_Rd_Data(a_rd_dat),
    .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr), .i_B_Wr_Data(b_wdat),
    .o_B_Ack(b_ack), .o_B_Rd_DV(b_rd_dv), .o_B_Rd_Data(b_rd_dat),
    .o_Ram_Addr(ram_addr), .o_Ram_Wr_DV(ram_wr_dv), .o_Ram_Wr_Data(ram_wr_dat),
    .o_Ram_Rd_En(ram_rd_en), .i_Ram_Rd_DV(ram_rd_dv), .i_Ram_Rd_Data(ram_rd_dat)
  );

  // Single-port RAM with one-cycle read latency.
  always @(posedge r_Clk) begin
    if (ram_wr_dv) mem[ram_addr] <= ram_wr_dat;
    ram_rd_dv <= ram_rd_en;
    if (ram_rd_en) ram_rd_dat <= mem[ram_addr];
  end

  typedef struct {
    int               due;
    int               who;
    logic [WIDTH-1:0] dat;
  } rd_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Requester command slots (0 = A, 1 = B)
  bit               pend [2];
  bit               pwr  [2];
  logic [AW-1:0]    padr [2];
  logic [WIDTH-1:0] pdat [2];

  // Reference model state
  int               m_owner = -1;
  int               m_run   = 0;
  int               m_last  = 1;
  logic [WIDTH-1:0] mmem [DEPTH];
  rd_t              rdq [$];
  logic             exp_wr = 1'b0;
  logic             exp_rd = 1'b0;
  logic [AW-1:0]    exp_addr = '0;
  logic [WIDTH-1:0] exp_dat = '0;
  int               pick;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_cmd(input int who, input bit wr, input logic [AW-1:0] adr, input logic [WIDTH-1:0] dat);
    pend[who] = 1'b1;
    pwr[who]  = wr;
    padr[who] = adr;
    pdat[who] = dat;
  endtask

  // One clock cycle: drive, check registered outputs / returns / acks, advance the model.
  task automatic tick(input bit rst);
    rd_t r;
    logic e_dv_a, e_dv_b;
    logic [WIDTH-1:0] e_d;
    int me, ot;
    @(posedge r_Clk);
    cyc++;
    #1;
    r_Rst  = rst;
    a_req  = pend[0]; a_wr = pwr[0]; a_addr = padr[0]; a_wdat = pdat[0];
    b_req  = pend[1]; b_wr = pwr[1]; b_addr = padr[1]; b_wdat = pdat[1];
    #1;
    check_val("ram_wr_dv",  ram_wr_dv,  exp_wr);
    check_val("ram_rd_en",  ram_rd_en,  exp_rd);
    check_val("ram_addr",   ram_addr,   exp_addr);
    check_val("ram_wr_dat", ram_wr_dat, exp_dat);
    if (rst) rdq.delete();
    e_dv_a = 1'b0; e_dv_b = 1'b0; e_d = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      e_d = r.dat;
      if (r.who == 0) e_dv_a = 1'b1; else e_dv_b = 1'b1;
    end
    check_val("a_rd_dv", a_rd_dv, e_dv_a);
    check_val("b_rd_dv", b_rd_dv, e_dv_b);
    if (e_dv_a) check_val("a_rd_dat", a_rd_dat, e_d);
    if (e_dv_b) check_val("b_rd_dat", b_rd_dat, e_d);
    pick = -1;
    if (!rst) begin
      if (m_owner < 0) begin
        if (pend[0] && pend[1]) pick = (RR && m_last == 0) ? 1 : 0;
        else if (pend[0])       pick = 0;
        else if (pend[1])       pick = 1;
      end else begin
        me = m_owner;
        ot = 1 - me;
        if (pend[me] && (m_run < MAX_BURST || !pend[ot])) pick = me;
        else if (pend[ot])                                 pick = ot;
      end
    end
    check_val("a_ack", a_ack, pick == 0);
    check_val("b_ack", b_ack, pick == 1);
    if (rst) begin
      m_owner = -1; m_run = 0; m_last = 1;
      exp_wr = 1'b0; exp_rd = 1'b0; exp_addr = '0; exp_dat = '0;
    end else if (pick >= 0) begin
      m_run   = (pick == m_owner) ? ((m_run < MAX_BURST) ? m_run + 1 : MAX_BURST) : 1;
      m_owner = pick;
      exp_wr  = pwr[pick];
      exp_rd  = !pwr[pick];
      exp_addr = padr[pick];
      exp_dat  = pdat[pick];
      if (pwr[pick]) mmem[padr[pick]] = pdat[pick];
      else begin
        r.due = cyc + 2; r.who = pick; r.dat = mmem[padr[pick]];
        rdq.push_back(r);
      end
      pend[pick] = 1'b0;
    end else begin
      if (m_owner >= 0) m_last = m_owner;
      m_owner = -1; m_run = 0;
      exp_wr = 1'b0; exp_rd = 1'b0;
    end
  endtask

  task automatic rand_cmd(input int who);
    set_cmd(who, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      mmem[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pwr[i] = 1'b0; padr[i] = '0; pdat[i] = '0;
    end

    // Reset state
    tick(1'b1);
    tick(1'b1);

    // A-only writes 1..4 to addresses 0..3, back-to-back
    for (int i = 0; i < 4; i++) begin
      set_cmd(0, 1'b1, AW'(i), WIDTH'(i + 1));
      tick(1'b0);
      check_val("dir_wr_ack", a_ack, 1'b1);
    end
    tick(1'b0);

    // A reads address 2, expecting 3 two cycles later
    set_cmd(0, 1'b0, 2'd2, '0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    check_val("dir_rd_dv_a2", a_rd_dv, 1'b1);
    check_val("dir_rd_dat_a2", a_rd_dat, 8'd3);
    tick(1'b0);

    // A reads 1 at N, B reads 3 at N+1
    set_cmd(0, 1'b0, 2'd1, '0);
    tick(1'b0);
    set_cmd(1, 1'b0, 2'd3, '0);
    tick(1'b0);
    tick(1'b0);
    check_val("dir_ab_dv_a", a_rd_dv, 1'b1);
    check_val("dir_ab_dat_a", a_rd_dat, 8'd2);
    tick(1'b0);
    check_val("dir_ab_dv_b", b_rd_dv, 1'b1);
    check_val("dir_ab_dat_b", b_rd_dat, 8'd4);
    tick(1'b0);

    // Both requesting continuously from reset: 4xA, 4xB, ... with no idle RAM cycle
    tick(1'b1);
    for (int i = 0; i < 24; i++) begin
      if (!pend[0]) rand_cmd(0);
      if (!pend[1]) rand_cmd(1);
      tick(1'b0);
      check_val("burst_owner_a", a_ack, ((i / MAX_BURST) % 2) == 0);
      check_val("burst_one_ack", 32'(a_ack) + 32'(b_ack), 1);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    tick(1'b0);
    tick(1'b0);

    // Idle tie after B was last owner, then after A was last owner
    set_cmd(1, 1'b1, 2'd0, 8'h55);
    tick(1'b0);
    tick(1'b0);
    set_cmd(0, 1'b0, 2'd0, '0);
    set_cmd(1, 1'b0, 2'd1, '0);
    tick(1'b0);
    check_val("tie_after_b", a_ack, 1'b1);
    pend[1] = 1'b0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    set_cmd(0, 1'b0, 2'd2, '0);
    set_cmd(1, 1'b0, 2'd3, '0);
    tick(1'b0);
    check_val("tie_after_a", b_ack, RR);
    pend[0] = 1'b0; pend[1] = 1'b0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);

    // Reset one cycle after an A read ack: the return must be dropped
    set_cmd(0, 1'b0, 2'd1, '0);
    tick(1'b0);
    tick(1'b1);
    check_val("rst_mid_rd_en", ram_rd_en, 1'b1);
    tick(1'b0);
    check_val("rst_rd_en_clr", ram_rd_en, 1'b0);
    tick(1'b0);
    check_val("rst_drop_dv_a", a_rd_dv, 1'b0);
    tick(1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int w = 0; w < 2; w++)
        if (!pend[w] && $urandom_range(0, 3) != 0) rand_cmd(w);
      tick($urandom_range(0, 149) == 0);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    check_val("drain_q_empty", rdq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
